hood_mode_fsm: RTL and testbench
================================

# hood_mode_fsm

- Parametrised range-hood mode controller running entirely on the 100 Hz system tick.
- Debounces the menu button and classifies presses as short or long.
- Sequences OFF / STANDBY / SMOKING / CLEANING with a configurable number of extraction levels, a timed turbo (top) level and a timed cleaning cycle.
- Sits between the front-panel input logic and the fan/display drivers, and replaces the fixed three-level controller.

## Interface

Parameters:
- NUM_LEVELS, 3: number of extraction levels (2..7); level NUM_LEVELS is turbo.
- TICKS_PER_SEC, 100: clk_100Hz cycles per second.
- CLEAN_SEC, 180: cleaning cycle length in seconds (1..65535).
- TURBO_SEC, 60: turbo run length in seconds (1..65535).
- TURBO_FALLBACK, 0: turbo expiry target; 0 = STANDBY, 1 = level NUM_LEVELS-1.
- DEBOUNCE_TICKS, 2: consecutive equal samples before the menu level is accepted.
- LONG_PRESS_TICKS, 300: hold length that qualifies as a long press.
- REMIND_SEC, 36000: cumulative SMOKING time before a clean reminder (feature-gated).

Ports (clock and reset per "Already decided": reset reset, asynchronous, active-high; clock clk_100Hz):
- clk_100Hz, input, 1: system tick clock.
- reset, input, 1: asynchronous active-high reset.
- power_on, input, 1: hood power enable, level-sensitive.
- factory_reset, input, 1: level-sensitive return to STANDBY with all counters cleared.
- menu, input, 1: raw menu button, active-high, asynchronous.
- req_clean, input, 1: cleaning selected on the panel.
- req_level, input, LW=$clog2(NUM_LEVELS+1): requested level; 0 = none.
- state, output, 2: 00 OFF, 01 STANDBY, 10 SMOKING, 11 CLEANING.
- level, output, LW: active level; 0 unless in SMOKING.
- remain_sec, output, 16: seconds left in turbo or cleaning; otherwise 0.
- clean_done, output, 1: one-cycle pulse when cleaning completes by timeout.
- clean_remind, output, 1: cleaning reminder; tied 0 when the feature is compiled out.

## Operation

Menu front end:
- 2-flop synchroniser, then a debounce counter. The stable level changes after DEBOUNCE_TICKS consecutive samples that differ from the current stable level.
- Hold counter runs while the stable level is 1.
- Long event fires once, in the cycle the hold count reaches LONG_PRESS_TICKS.
- Short event fires on a stable 1->0 transition if no long event fired during that press.
- Events are single-cycle registered flags.

State machine, evaluated in priority order:
1. power_on=0: go to OFF from any state, clearing level, remain_sec and the tick/second counters. Overrides everything else.
2. factory_reset=1 (with power_on=1): go to STANDBY, level=0, remain_sec=0, reminder accumulator cleared. Pending events are discarded.
3. Timer expiry: takes priority over a button event in the same cycle; the event is dropped.
4. Button events.

Transitions:
- OFF: go to STANDBY on the first cycle with power_on=1.
- STANDBY, short event:
  - req_clean=1 → CLEANING with remain_sec=CLEAN_SEC. req_clean wins over req_level.
  - Otherwise req_level in 1..NUM_LEVELS → SMOKING with level=req_level.
  - If level is NUM_LEVELS, also load remain_sec=TURBO_SEC.
  - req_level=0 or >NUM_LEVELS is ignored.
  - Long events are ignored.
- SMOKING, level<NUM_LEVELS: short event → STANDBY. Long event ignored.
- SMOKING, turbo: short event ignored (turbo is locked). Long event → STANDBY.
  - On expiry: TURBO_FALLBACK=0 → STANDBY. TURBO_FALLBACK=1 → stay in SMOKING at level NUM_LEVELS-1 with remain_sec=0.
- CLEANING: short event ignored. Long event aborts to STANDBY with no clean_done. On expiry → STANDBY and clean_done=1 for one cycle.

Timers:
- Tick counter runs 0..TICKS_PER_SEC-1 only while a timed mode is active, and is cleared on entry.
- remain_sec decrements on each wrap.
- The transition is taken at the same edge that remain_sec goes 1→0.
- A timed mode therefore lasts exactly SEC*TICKS_PER_SEC cycles from its entry edge.

## Timing

- Reset values: state=00, level=0, remain_sec=0, clean_done=0, clean_remind=0. Synchroniser, debounce, hold, tick and accumulator counters are all 0.
- Short press latency: state changes 2+DEBOUNCE_TICKS+1 cycles after menu falls, provided the hold stayed below LONG_PRESS_TICKS.
- Long press latency: the action occurs 2+DEBOUNCE_TICKS+LONG_PRESS_TICKS+1 cycles after menu rises. The subsequent release produces no short event.
- All outputs are registered. clean_done is coincident with the CLEANING→STANDBY edge.
- Deasserting reset mid-operation restarts from OFF. A press in progress at reset release must be fully released before it can produce an event.

## Configuration

- Macro HOOD_CLEAN_REMIND_EN.
- Defined:
  - A 32-bit second accumulator increments once per second while state=SMOKING. It saturates and is not cleared by power_on=0.
  - clean_remind=1 once the accumulator reaches REMIND_SEC.
  - A completed cleaning (clean_done) or factory_reset clears both the accumulator and clean_remind. An aborted cleaning does not.
- Undefined: no accumulator logic is built and clean_remind is constant 0.

## Test plan

Bench parameters: TICKS_PER_SEC=4, CLEAN_SEC=3, TURBO_SEC=2, DEBOUNCE_TICKS=2, LONG_PRESS_TICKS=8, REMIND_SEC=5.

- Power up, STANDBY, req_level=2, 4-cycle press → SMOKING, level=2, 5 cycles after release. Second short press → STANDBY.
- req_clean=1 with req_level=1, short press → CLEANING with remain_sec=3. After 12 cycles → STANDBY with a one-cycle clean_done.
- req_level=3 (turbo): short press during turbo is ignored. At 8 cycles: TURBO_FALLBACK=0 → STANDBY; TURBO_FALLBACK=1 → SMOKING, level=2, remain_sec=0.
- CLEANING, hold menu for 12 cycles → STANDBY exactly once at the long-press point. No clean_done, and no action on release.
- power_on dropped mid-CLEANING → OFF next edge with remain_sec=0. Raise power_on together with factory_reset=1 → STANDBY. A press arriving in the same cycle as expiry is discarded.
- With HOOD_CLEAN_REMIND_EN: 5 s of SMOKING → clean_remind=1. Aborted cleaning leaves it at 1; a completed cleaning clears it to 0.

Source files
------------

// File: rtl/hood_mode_fsm.sv
// Range-hood mode controller on the 100 Hz tick: menu debounce/press classification, mode FSM,
// turbo/cleaning timers. Define HOOD_CLEAN_REMIND_EN to build the cumulative clean reminder.
module hood_mode_fsm #(
  parameter int unsigned NUM_LEVELS       = 3,
  parameter int unsigned TICKS_PER_SEC    = 100,
  parameter int unsigned CLEAN_SEC        = 180,
  parameter int unsigned TURBO_SEC        = 60,
  parameter int unsigned TURBO_FALLBACK   = 0,
  parameter int unsigned DEBOUNCE_TICKS   = 2,
  parameter int unsigned LONG_PRESS_TICKS = 300,
  parameter int unsigned REMIND_SEC       = 36000,
  localparam int unsigned LW              = $clog2(NUM_LEVELS + 1)
) (
  input  logic          clk_100Hz,
  input  logic          reset,
  input  logic          power_on,
  input  logic          factory_reset,
  input  logic          menu,
  input  logic          req_clean,
  input  logic [LW-1:0] req_level,
  output logic [1:0]    state,
  output logic [LW-1:0] level,
  output logic [15:0]   remain_sec,
  output logic          clean_done,
  output logic          clean_remind
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HW = $clog2(LONG_PRESS_TICKS + 1);

  localparam logic [TW-1:0] TickMax   = TW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DbLast    = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HoldMax   = HW'(LONG_PRESS_TICKS);
  localparam logic [HW-1:0] HoldLast  = HW'(LONG_PRESS_TICKS - 1);
  localparam logic [LW-1:0] LvlTop    = LW'(NUM_LEVELS);
  localparam logic [LW-1:0] LvlFb     = LW'(NUM_LEVELS - 1);
  localparam logic [15:0]   CleanLoad = 16'(CLEAN_SEC);
  localparam logic [15:0]   TurboLoad = 16'(TURBO_SEC);

  typedef enum logic [1:0] {
    StOff      = 2'b00,
    StStandby  = 2'b01,
    StSmoking  = 2'b10,
    StCleaning = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Menu front end
  // ---------------------------------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_fired_q, long_fired_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          short_ev_q, short_ev_d;
  logic          long_ev_q, long_ev_d;
  logic          db_fall, long_now;

  always_comb begin
    db_d         = db_q;
    db_cnt_d     = '0;
    hold_d       = '0;
    long_fired_d = long_fired_q;
    fill_d       = fill_q;
    armed_d      = armed_q;
    short_ev_d   = 1'b0;
    long_ev_d    = 1'b0;

    if (fill_q != 2'd2) fill_d = fill_q + 2'd1;

    if (sync2_q != db_q) begin
      if (db_cnt_q == DbLast) db_d = sync2_q;
      else                    db_cnt_d = db_cnt_q + DW'(1);
    end

    db_fall  = db_q && !sync2_q && (db_cnt_q == DbLast);
    long_now = db_q && (hold_q == HoldLast);

    if (db_q) hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HW'(1);

    if (long_now) long_fired_d = 1'b1;
    if (db_fall)  long_fired_d = 1'b0;

    // A press held across reset release stays disarmed until the button is seen released.
    if ((fill_q == 2'd2) && !sync2_q && !db_q) armed_d = 1'b1;

    long_ev_d  = armed_q && long_now;
    short_ev_d = armed_q && db_fall && !long_fired_q && !long_now;
  end

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_q         <= 1'b0;
      db_cnt_q     <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      fill_q       <= 2'd0;
      armed_q      <= 1'b0;
      short_ev_q   <= 1'b0;
      long_ev_q    <= 1'b0;
    end else begin
      sync1_q      <= menu;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      short_ev_q   <= short_ev_d;
      long_ev_q    <= long_ev_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Mode state machine and timers
  // ---------------------------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   remain_q, remain_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          clean_done_q, clean_done_d;
  logic          timed, wrap, expire;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    remain_d     = remain_q;
    tick_d       = tick_q;
    clean_done_d = 1'b0;

    timed  = (state_q == StCleaning) || ((state_q == StSmoking) && (level_q == LvlTop));
    wrap   = (tick_q == TickMax);
    expire = timed && wrap && (remain_q == 16'd1);

    if (timed) begin
      if (wrap) begin
        tick_d   = '0;
        remain_d = remain_q - 16'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (!power_on) begin
      state_d  = StOff;
      level_d  = '0;
      remain_d = '0;
      tick_d   = '0;
    end else if (factory_reset) begin
      state_d  = StStandby;
      level_d  = '0;
      remain_d = '0;
      tick_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StStandby;
        end
        StStandby: begin
          if (short_ev_q) begin
            if (req_clean) begin
              state_d  = StCleaning;
              remain_d = CleanLoad;
              tick_d   = '0;
            end else if ((req_level != '0) && (req_level <= LvlTop)) begin
              state_d  = StSmoking;
              level_d  = req_level;
              tick_d   = '0;
              remain_d = (req_level == LvlTop) ? TurboLoad : 16'd0;
            end
          end
        end
        StSmoking: begin
          if (level_q == LvlTop) begin
            // Expiry wins over a coincident long press; turbo ignores short presses.
            if (expire) begin
              remain_d = '0;
              tick_d   = '0;
              if (TURBO_FALLBACK != 0) begin
                level_d = LvlFb;
              end else begin
                state_d = StStandby;
                level_d = '0;
              end
            end else if (long_ev_q) begin
              state_d  = StStandby;
              level_d  = '0;
              remain_d = '0;
              tick_d   = '0;
            end
          end else if (short_ev_q) begin
            state_d = StStandby;
            level_d = '0;
          end
        end
        StCleaning: begin
          if (expire) begin
            state_d      = StStandby;
            remain_d     = '0;
            tick_d       = '0;
            clean_done_d = 1'b1;
          end else if (long_ev_q) begin
            state_d  = StStandby;
            remain_d = '0;
            tick_d   = '0;
          end
        end
        default: begin
          state_d = StOff;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      state_q      <= StOff;
      level_q      <= '0;
      remain_q     <= '0;
      tick_q       <= '0;
      clean_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      remain_q     <= remain_d;
      tick_q       <= tick_d;
      clean_done_q <= clean_done_d;
    end
  end

  assign state      = state_q;
  assign level      = level_q;
  assign remain_sec = remain_q;
  assign clean_done = clean_done_q;

  // ---------------------------------------------------------------------------------------------
  // Clean reminder
  // ---------------------------------------------------------------------------------------------
`ifdef HOOD_CLEAN_REMIND_EN
  localparam logic [31:0] RemindCnt = 32'(REMIND_SEC);

  logic [31:0]   acc_q, acc_d;
  logic [TW-1:0] sec_q, sec_d;
  logic          remind_q, remind_d;

  always_comb begin
    acc_d = acc_q;
    sec_d = '0;
    // Power-off leaves the accumulator intact; only the sub-second prescaler is dropped.
    if (power_on) begin
      if (factory_reset || clean_done_d) begin
        acc_d = '0;
      end else if (state_q == StSmoking) begin
        if (sec_q == TickMax) begin
          if (acc_q != '1) acc_d = acc_q + 32'd1;
        end else begin
          sec_d = sec_q + TW'(1);
        end
      end
    end
    remind_d = (acc_d >= RemindCnt);
  end

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      sec_q    <= '0;
      remind_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sec_q    <= sec_d;
      remind_q <= remind_d;
    end
  end

  assign clean_remind = remind_q;
`else
  logic unused_remind_cfg;
  assign unused_remind_cfg = ^REMIND_SEC;
  assign clean_remind      = 1'b0;
`endif

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Directed bench for hood_mode_fsm; two instances differ only in TURBO_FALLBACK.
module tb_hood_mode_fsm;

  logic        clk_100Hz = 1'b0;
  logic        reset = 1'b1;
  logic        power_on = 1'b0;
  logic        factory_reset = 1'b0;
  logic        menu = 1'b0;
  logic        req_clean = 1'b0;
  logic [1:0]  req_level = 2'd0;

  logic [1:0]  state0, state1, level0, level1;
  logic [15:0] remain0, remain1;
  logic        done0, done1, remind0, remind1;

  int checks = 0;
  int errors = 0;

  always #5 clk_100Hz = ~clk_100Hz;

  hood_mode_fsm #(
    .NUM_LEVELS(3), .TICKS_PER_SEC(4), .CLEAN_SEC(3), .TURBO_SEC(2), .TURBO_FALLBACK(0),
    .DEBOUNCE_TICKS(2), .LONG_PRESS_TICKS(8), .REMIND_SEC(5)
  ) dut0 (
    .clk_100Hz(clk_100Hz), .reset(reset), .power_on(power_on), .factory_reset(factory_reset),
    .menu(menu), .req_clean(req_clean), .req_level(req_level), .state(state0), .level(level0),
    .remain_sec(remain0), .clean_done(done0), .clean_remind(remind0)
  );

  hood_mode_fsm #(
    .NUM_LEVELS(3), .TICKS_PER_SEC(4), .CLEAN_SEC(3), .TURBO_SEC(2), .TURBO_FALLBACK(1),
    .DEBOUNCE_TICKS(2), .LONG_PRESS_TICKS(8), .REMIND_SEC(5)
  ) dut1 (
    .clk_100Hz(clk_100Hz), .reset(reset), .power_on(power_on), .factory_reset(factory_reset),
    .menu(menu), .req_clean(req_clean), .req_level(req_level), .state(state1), .level(level1),
    .remain_sec(remain1), .clean_done(done1), .clean_remind(remind1)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100Hz);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    chk("rst_state", 32'(state0), 32'd0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_remain", 32'(remain0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_remind", 32'(remind0), 32'd0);

    reset = 1'b0;
    power_on = 1'b1;
    step(1);
    chk("off_to_standby", 32'(state0), 32'd1);
    step(3);

    // Short press, level 2: acts 5 edges after release
    req_level = 2'd2;
    menu = 1'b1; step(4); menu = 1'b0; step(4);
    chk("short_latency_early", 32'(state0), 32'd1);
    step(1);
    chk("smoke_state", 32'(state0), 32'd2);
    chk("smoke_level", 32'(level0), 32'd2);
    chk("smoke_remain", 32'(remain0), 32'd0);
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("smoke_exit_state", 32'(state0), 32'd1);
    chk("smoke_exit_level", 32'(level0), 32'd0);

    // req_level 0 is ignored
    req_level = 2'd0;
    menu = 1'b1; step(4); menu = 1'b0; step(8);
    chk("level0_ignored", 32'(state0), 32'd1);

    // Completed cleaning, req_clean beats req_level
    req_clean = 1'b1; req_level = 2'd1;
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("clean_state", 32'(state0), 32'd3);
    chk("clean_remain", 32'(remain0), 32'd3);
    chk("clean_level", 32'(level0), 32'd0);
    step(4);
    chk("clean_remain_4", 32'(remain0), 32'd2);
    step(7);
    chk("clean_state_11", 32'(state0), 32'd3);
    chk("clean_remain_11", 32'(remain0), 32'd1);
    chk("clean_done_11", 32'(done0), 32'd0);
    step(1);
    chk("clean_end_state", 32'(state0), 32'd1);
    chk("clean_end_done", 32'(done0), 32'd1);
    chk("clean_end_remain", 32'(remain0), 32'd0);
    step(1);
    chk("clean_done_pulse", 32'(done0), 32'd0);

    // Turbo with short press ignored, then expiry on both fallback settings
    req_clean = 1'b0; req_level = 2'd3;
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("turbo_state", 32'(state0), 32'd2);
    chk("turbo_level", 32'(level0), 32'd3);
    chk("turbo_remain", 32'(remain0), 32'd2);
    chk("turbo_level_fb1", 32'(level1), 32'd3);
    menu = 1'b1; step(2); menu = 1'b0; step(5);
    chk("turbo_locked_state", 32'(state0), 32'd2);
    chk("turbo_locked_level", 32'(level0), 32'd3);
    chk("turbo_remain_7", 32'(remain0), 32'd1);
    step(1);
    chk("turbo_exp_state_fb0", 32'(state0), 32'd1);
    chk("turbo_exp_level_fb0", 32'(level0), 32'd0);
    chk("turbo_exp_remain_fb0", 32'(remain0), 32'd0);
    chk("turbo_exp_state_fb1", 32'(state1), 32'd2);
    chk("turbo_exp_level_fb1", 32'(level1), 32'd2);
    chk("turbo_exp_remain_fb1", 32'(remain1), 32'd0);
    power_on = 1'b0; step(1);
    chk("realign_off_fb1", 32'(state1), 32'd0);
    power_on = 1'b1; step(3);

    // Long press aborts cleaning: new press begins while the entering release still debounces
    req_clean = 1'b1;
    menu = 1'b1; step(4); menu = 1'b0; step(2); menu = 1'b1; step(3);
    chk("abort_enter", 32'(state0), 32'd3);
    chk("abort_enter_remain", 32'(remain0), 32'd3);
    step(9);
    chk("abort_before", 32'(state0), 32'd3);
    menu = 1'b0; step(1);
    chk("abort_state", 32'(state0), 32'd1);
    chk("abort_no_done", 32'(done0), 32'd0);
    chk("abort_remain", 32'(remain0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("abort_quiet_state", 32'(state0), 32'd1);
      chk("abort_quiet_done", 32'(done0), 32'd0);
    end

    // Long event lands on the expiry edge: expiry wins, so clean_done still pulses
    menu = 1'b1; step(4); menu = 1'b0; step(4); menu = 1'b1; step(1);
    chk("coinc_enter", 32'(state0), 32'd3);
    step(11);
    chk("coinc_state_11", 32'(state0), 32'd3);
    chk("coinc_remain_11", 32'(remain0), 32'd1);
    menu = 1'b0; step(1);
    chk("coinc_state", 32'(state0), 32'd1);
    chk("coinc_done", 32'(done0), 32'd1);
    step(1);
    chk("coinc_done_pulse", 32'(done0), 32'd0);
    step(6);
    chk("coinc_release_ignored", 32'(state0), 32'd1);

    // Power drop mid-cleaning, then power-up with factory reset
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("pwr_clean_enter", 32'(state0), 32'd3);
    step(3);
    power_on = 1'b0; step(1);
    chk("pwr_off_state", 32'(state0), 32'd0);
    chk("pwr_off_remain", 32'(remain0), 32'd0);
    chk("pwr_off_done", 32'(done0), 32'd0);
    power_on = 1'b1; factory_reset = 1'b1; step(1);
    chk("factory_state", 32'(state0), 32'd1);
    chk("factory_remain", 32'(remain0), 32'd0);
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("factory_discard", 32'(state0), 32'd1);
    factory_reset = 1'b0; step(3);
    chk("factory_after", 32'(state0), 32'd1);

`ifdef HOOD_CLEAN_REMIND_EN
    factory_reset = 1'b1; step(1); factory_reset = 1'b0;
    chk("remind_cleared", 32'(remind0), 32'd0);
    req_clean = 1'b0; req_level = 2'd1;
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("remind_smoke", 32'(state0), 32'd2);
    step(19);
    chk("remind_before", 32'(remind0), 32'd0);
    step(1);
    chk("remind_set", 32'(remind0), 32'd1);
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("remind_standby", 32'(state0), 32'd1);
    req_clean = 1'b1;
    menu = 1'b1; step(4); menu = 1'b0; step(2); menu = 1'b1; step(3);
    chk("remind_abort_enter", 32'(state0), 32'd3);
    step(9); menu = 1'b0; step(1);
    chk("remind_abort_state", 32'(state0), 32'd1);
    chk("remind_after_abort", 32'(remind0), 32'd1);
    step(6);
    menu = 1'b1; step(4); menu = 1'b0; step(5);
    chk("remind_clean_enter", 32'(state0), 32'd3);
    step(12);
    chk("remind_clean_done", 32'(done0), 32'd1);
    chk("remind_after_clean", 32'(remind0), 32'd0);
`else
    chk("remind_tied_low", 32'(remind0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
